// File: rtl/wb_pkg.sv
// Writeback stage shared types: result kinds, FSM states, gather timeout.
// Imported by wb_stage and vec_lane_assembler.
package wb_pkg;

  typedef enum logic [1:0] {
    INT_ALU  = 2'd0,
    VEC_ALU  = 2'd1,
    SCL_LOAD = 2'd2,
    VEC_LOAD = 2'd3
  } result_kind_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_COMMIT = 2'd2,
    S_HALT   = 2'd3
  } wb_state_e;

  localparam int GATHER_TIMEOUT = 15;

endpackage

// File: rtl/wb_stage_vec_lane_assembler.sv
// Element-serial lane assembler: lane counter, element storage, done pulse.
// Ports: i_clr clears, i_en+i_vld stores a lane, o_vec_nxt/o_done for commit.
module vec_lane_assembler
  import wb_pkg::*;
#(
  parameter int VECT_SIZE = 8,
  parameter int ELEM_SIZE = 8,
  parameter int CW        = $clog2(VECT_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clr,
  input  logic                         i_en,
  input  logic                         i_vld,
  input  logic [ELEM_SIZE-1:0]         i_elem,
  input  logic [CW-1:0]                i_last,
  output logic [VECT_SIZE*ELEM_SIZE-1:0] o_vec_nxt,
  output logic                         o_done
);

  logic [CW-1:0]                r_cnt;
  logic [VECT_SIZE*ELEM_SIZE-1:0] r_vec;
  logic                         w_beat;

  assign w_beat = i_en && i_vld;
  assign o_done = w_beat && (r_cnt == i_last);

  // Storage with the incoming lane already merged, so the final beat
  // can be committed on the same edge that captures it.
  always_comb begin
    o_vec_nxt = r_vec;
    o_vec_nxt[r_cnt*ELEM_SIZE +: ELEM_SIZE] = i_elem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_vec <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_vec <= '0;
    end else if (w_beat) begin
      r_cnt <= r_cnt + 1'b1;
      r_vec <= o_vec_nxt;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: ALU results and gathered loads to int/vec RF write ports.
// Optional macro WB_GATHER_TIMEOUT_EN aborts a stalled gather.
module wb_stage
  import wb_pkg::*;
#(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter int REGI_SIZE = 16,
  parameter int VECT_SIZE = 8,
  parameter int ELEM_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_i,
  input  logic [1:0]                   kind_i,
  input  logic                         end_i,
  input  logic [REGI_BITS-1:0]         int_dst_i,
  input  logic [VECT_BITS-1:0]         vec_dst_i,
  input  logic [REGI_SIZE-1:0]         int_res_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_res_i,
  input  logic                         mem_vld_i,
  input  logic [ELEM_SIZE-1:0]         mem_elem_i,
  output logic                         int_we_o,
  output logic [REGI_BITS-1:0]         int_wa_o,
  output logic [REGI_SIZE-1:0]         int_wd_o,
  output logic                         vec_we_o,
  output logic [VECT_BITS-1:0]         vec_wa_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] vec_wd_o,
  output logic                         stall_o,
  output logic                         halted_o,
  output logic                         err_o
);

  localparam int CW = $clog2(VECT_SIZE);

  wb_state_e                    r_state;
  logic                         r_is_vec;
  logic                         r_end;
  logic [REGI_BITS-1:0]         r_ld_ia;
  logic [VECT_BITS-1:0]         r_ld_va;
  logic [ELEM_SIZE*VECT_SIZE-1:0] w_vec_nxt;
  logic                         w_done;
  logic                         w_gather;
  logic [CW-1:0]                w_last;

  assign stall_o  = (r_state != S_IDLE);
  assign w_gather = (r_state == S_GATHER);
  assign w_last   = r_is_vec ? CW'(VECT_SIZE-1) : '0;

  vec_lane_assembler #(
    .VECT_SIZE (VECT_SIZE),
    .ELEM_SIZE (ELEM_SIZE)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (!w_gather),
    .i_en      (w_gather),
    .i_vld     (mem_vld_i),
    .i_elem    (mem_elem_i),
    .i_last    (w_last),
    .o_vec_nxt (w_vec_nxt),
    .o_done    (w_done)
  );

`ifdef WB_GATHER_TIMEOUT_EN
  logic [3:0] r_idle;
  logic       w_tmo;
  assign w_tmo = w_gather && !mem_vld_i
              && (r_idle == 4'(GATHER_TIMEOUT-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_idle <= '0;
    else if (!w_gather || mem_vld_i || w_tmo)
      r_idle <= '0;
    else
      r_idle <= r_idle + 1'b1;
  end
`else
  logic w_tmo;
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_is_vec <= 1'b0;
      r_end    <= 1'b0;
      r_ld_ia  <= '0;
      r_ld_va  <= '0;
      int_we_o <= 1'b0;
      int_wa_o <= '0;
      int_wd_o <= '0;
      vec_we_o <= 1'b0;
      vec_wa_o <= '0;
      vec_wd_o <= '0;
      halted_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      int_we_o <= 1'b0;
      vec_we_o <= 1'b0;
      if (valid_i && stall_o)
        err_o <= 1'b1;
      if (mem_vld_i && (r_state == S_IDLE || r_state == S_COMMIT))
        err_o <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            unique case (result_kind_e'(kind_i))
              INT_ALU: begin
                int_we_o <= 1'b1;
                int_wa_o <= int_dst_i;
                int_wd_o <= int_res_i;
              end
              VEC_ALU: begin
                vec_we_o <= 1'b1;
                vec_wa_o <= vec_dst_i;
                vec_wd_o <= vec_res_i;
              end
              SCL_LOAD, VEC_LOAD: begin
                r_ld_ia  <= int_dst_i;
                r_ld_va  <= vec_dst_i;
                r_is_vec <= kind_i[0];
              end
            endcase
            // Loads defer the halt until their commit.
            r_end <= end_i;
            if (kind_i[1])
              r_state <= S_GATHER;
            else if (end_i) begin
              r_state  <= S_HALT;
              halted_o <= 1'b1;
            end
          end
        end
        S_GATHER: begin
          if (w_tmo) begin
            r_state <= S_IDLE;
            err_o   <= 1'b1;
          end else if (w_done) begin
            r_state <= S_COMMIT;
            if (r_is_vec) begin
              vec_we_o <= 1'b1;
              vec_wa_o <= r_ld_va;
              vec_wd_o <= w_vec_nxt;
            end else begin
              int_we_o <= 1'b1;
              int_wa_o <= r_ld_ia;
              int_wd_o <= REGI_SIZE'(w_vec_nxt[ELEM_SIZE-1:0]);
            end
          end
        end
        S_COMMIT: begin
          if (r_end) begin
            r_state  <= S_HALT;
            halted_o <= 1'b1;
          end else
            r_state <= S_IDLE;
        end
        S_HALT: r_state <= S_HALT;
      endcase
    end
  end

endmodule
